// File: rtl/charram_dram_sequencer.sv
// charram_dram_sequencer
//   Slot sequencer for one 4416-type character-RAM DRAM plane (16k x 4,
//   8-bit multiplexed address). Alternating 8-cycle slots give the plane
//   to the video fetcher (slot 0) and the CPU (slot 1). Each slot does
//   one row/column access and returns the nibble to the slot owner.
//
// Ports
//   i_MCLK, i_RST         clock, synchronous active-high reset
//   i_VADDR               video address, [7:0] row, [13:8] column
//   o_VDATA/_VALID        video read nibble and its one-cycle strobe
//   i_CPU_REQ/_WR/_ADDR/_DIN  CPU request (level, held until ack)
//   o_CPU_DOUT/o_CPU_ACK  CPU read nibble and one-cycle completion pulse
//   o_ADDR, o_DIN, i_DOUT DRAM multiplexed address, write data, read data
//   o_RAS_n .. o_RD_n     DRAM strobes, active low
module charram_dram_sequencer (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic [13:0] i_VADDR,
  output logic [3:0]  o_VDATA,
  output logic        o_VDATA_VALID,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [13:0] i_CPU_ADDR,
  input  logic [3:0]  i_CPU_DIN,
  output logic [3:0]  o_CPU_DOUT,
  output logic        o_CPU_ACK,
  output logic [7:0]  o_ADDR,
  output logic [3:0]  o_DIN,
  input  logic [3:0]  i_DOUT,
  output logic        o_RAS_n,
  output logic        o_CAS_n,
  output logic        o_WR_n,
  output logic        o_RD_n
);

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_VID_RD,
    ACC_CPU_RD,
    ACC_CPU_WR
  } acc_e;

  logic [2:0]  phase;     // phase of the slot currently on the pins
  logic        slot_cpu;  // 0 = video slot, 1 = CPU slot
  acc_e        acc;       // access kind owning the current slot
  logic [13:0] acc_addr;
  logic [3:0]  acc_din;
  logic        acc_active;

  always_comb begin
    acc_active = (acc != ACC_IDLE);
  end

  // Every output is registered, so each branch below is keyed on the
  // current phase and loads the pin values for the phase that follows.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      phase         <= 3'd0;
      slot_cpu      <= 1'b0;
      acc           <= ACC_VID_RD;
      acc_addr      <= '0;
      acc_din       <= '0;
      o_RAS_n       <= 1'b1;
      o_CAS_n       <= 1'b1;
      o_WR_n        <= 1'b1;
      o_RD_n        <= 1'b1;
      o_ADDR        <= '0;
      o_DIN         <= '0;
      o_VDATA       <= '0;
      o_VDATA_VALID <= 1'b0;
      o_CPU_DOUT    <= '0;
      o_CPU_ACK     <= 1'b0;
    end else begin
      phase         <= phase + 3'd1;
      o_VDATA_VALID <= 1'b0;
      o_CPU_ACK     <= 1'b0;
      case (phase)
        3'd7: begin
          // Entering p0 of the next slot: pick owner and latch the request.
          slot_cpu <= ~slot_cpu;
          o_RAS_n  <= 1'b1;
          o_CAS_n  <= 1'b1;
          o_WR_n   <= 1'b1;
          o_RD_n   <= 1'b1;
          o_DIN    <= '0;
          if (slot_cpu) begin
            acc      <= ACC_VID_RD;
            acc_addr <= i_VADDR;
            o_ADDR   <= i_VADDR[7:0];
          end else if (i_CPU_REQ) begin
            acc      <= i_CPU_WR ? ACC_CPU_WR : ACC_CPU_RD;
            acc_addr <= i_CPU_ADDR;
            acc_din  <= i_CPU_DIN;
            o_ADDR   <= i_CPU_ADDR[7:0];
          end else begin
            acc <= ACC_IDLE;
          end
        end
        3'd0: begin
          if (acc_active) o_RAS_n <= 1'b0;
        end
        3'd1: begin
          // p2: row stays on the bus for a second cycle
        end
        3'd2: begin
          // Column goes out together with /CAS so the row latch never
          // sees it; the 6-bit column sits on ADDR[6:1].
          if (acc_active) begin
            o_CAS_n <= 1'b0;
            o_ADDR  <= {1'b0, acc_addr[13:8], 1'b0};
          end
          if (acc == ACC_CPU_WR) o_DIN <= acc_din;
        end
        3'd3: begin
          if (acc == ACC_CPU_WR) o_WR_n <= 1'b0;
          else if (acc_active)   o_RD_n <= 1'b0;
        end
        3'd4: begin
          o_WR_n <= 1'b1;
          o_RD_n <= 1'b1;
        end
        3'd5: begin
          // i_DOUT is valid during p5 and is captured on this edge.
          o_DIN <= '0;
          case (acc)
            ACC_VID_RD: begin
              o_VDATA       <= i_DOUT;
              o_VDATA_VALID <= 1'b1;
            end
            ACC_CPU_RD: begin
              o_CPU_DOUT <= i_DOUT;
              o_CPU_ACK  <= 1'b1;
            end
            ACC_CPU_WR: o_CPU_ACK <= 1'b1;
            ACC_IDLE:   ;
          endcase
        end
        3'd6: begin
          o_RAS_n <= 1'b1;
          o_CAS_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_charram_dram_sequencer.sv
module tb_charram_dram_sequencer;

  logic        clk = 1'b0;
  logic        i_RST = 1'b1;
  logic [13:0] i_VADDR = '0;
  logic [3:0]  o_VDATA;
  logic        o_VDATA_VALID;
  logic        i_CPU_REQ = 1'b0;
  logic        i_CPU_WR = 1'b0;
  logic [13:0] i_CPU_ADDR = '0;
  logic [3:0]  i_CPU_DIN = '0;
  logic [3:0]  o_CPU_DOUT;
  logic        o_CPU_ACK;
  logic [7:0]  o_ADDR;
  logic [3:0]  o_DIN;
  logic [3:0]  i_DOUT;
  logic        o_RAS_n, o_CAS_n, o_WR_n, o_RD_n;

  charram_dram_sequencer dut (
    .i_MCLK(clk), .i_RST(i_RST), .i_VADDR(i_VADDR),
    .o_VDATA(o_VDATA), .o_VDATA_VALID(o_VDATA_VALID),
    .i_CPU_REQ(i_CPU_REQ), .i_CPU_WR(i_CPU_WR), .i_CPU_ADDR(i_CPU_ADDR),
    .i_CPU_DIN(i_CPU_DIN), .o_CPU_DOUT(o_CPU_DOUT), .o_CPU_ACK(o_CPU_ACK),
    .o_ADDR(o_ADDR), .o_DIN(o_DIN), .i_DOUT(i_DOUT),
    .o_RAS_n(o_RAS_n), .o_CAS_n(o_CAS_n), .o_WR_n(o_WR_n), .o_RD_n(o_RD_n)
  );

  always #5 clk = ~clk;

  localparam int K_IDLE = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;

  typedef struct {
    int       cyc;
    logic [3:0] data;
  } exp_t;

  exp_t vid_q[$];
  exp_t cpu_q[$];
  int   cpu_kind[int];   // CPU slot base cycle -> access kind
  int   cyc = 0;         // cycles since reset release; 0 is the first video p0
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  // Nibbles preloaded into the DRAM model at these addresses.
  function automatic logic [3:0] exp_video(logic [13:0] a);
    case (a)
      14'h0000: return 4'h6;
      14'h2A5C: return 4'hB;
      default:  return 4'h0;
    endcase
  endfunction

  // {RAS_n, CAS_n, WR_n, RD_n} required at each phase of a slot.
  function automatic logic [3:0] exp_strobes(int ph, int kind);
    logic ras, cas, wr, rd;
    if (kind == K_IDLE) return 4'hF;
    ras = !(ph >= 1 && ph <= 6);
    cas = !(ph >= 3 && ph <= 6);
    wr  = !(kind == K_WR && ph == 4);
    rd  = !(kind == K_RD && ph == 4);
    return {ras, cas, wr, rd};
  endfunction

  always @(posedge clk) cyc <= i_RST ? 0 : cyc + 1;

  // DRAM model: row latched on /RAS fall, column on /CAS fall,
  // registered read data appears the cycle after /RD.
  logic [3:0] mem [16384];
  logic [7:0] m_row = '0;
  logic [5:0] m_col = '0;
  logic       m_ras_q = 1'b1, m_cas_q = 1'b1;
  bit         loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 4'h0;
      mem[14'h0000] <= 4'h6;
      mem[14'h2A5C] <= 4'hB;
      loaded <= 1'b1;
      i_DOUT <= 4'h0;
    end else begin
      m_ras_q <= o_RAS_n;
      m_cas_q <= o_CAS_n;
      if (!o_RAS_n && m_ras_q) m_row <= o_ADDR;
      if (!o_CAS_n && m_cas_q) m_col <= o_ADDR[6:1];
      if (!o_WR_n) mem[{m_col, m_row}] <= o_DIN;
      if (!o_RD_n) i_DOUT <= mem[{m_col, m_row}];
    end
  end

  // Video expectations: one read per video slot of the address on i_VADDR at p0.
  always @(negedge clk) begin
    if (!i_RST && (cyc % 16) == 0)
      vid_q.push_back('{cyc + 6, exp_video(i_VADDR)});
  end

  // Monitor: strobe pattern every cycle, and scoreboard pops on each output pulse.
  int  m_ph, m_kind, m_base;
  exp_t m_e;
  always @(negedge clk) begin
    if (!i_RST) begin
      m_ph   = cyc % 8;
      m_base = cyc - m_ph;
      if (((cyc / 8) % 2) == 0) m_kind = K_RD;
      else m_kind = cpu_kind.exists(m_base) ? cpu_kind[m_base] : K_IDLE;
      check("strobes", {12'h0, o_RAS_n, o_CAS_n, o_WR_n, o_RD_n},
            {12'h0, exp_strobes(m_ph, m_kind)});

      if (o_VDATA_VALID && o_CPU_ACK) check("valid_ack_overlap", 16'd1, 16'd0);

      if (o_VDATA_VALID) begin
        if (vid_q.size() == 0) check("vdata_unexpected", 16'd1, 16'd0);
        else begin
          m_e = vid_q.pop_front();
          check("vdata_cycle", cyc[15:0], m_e.cyc[15:0]);
          check("vdata", {12'h0, o_VDATA}, {12'h0, m_e.data});
        end
      end else if (vid_q.size() != 0 && vid_q[0].cyc <= cyc) begin
        m_e = vid_q.pop_front();
        check("vdata_missing", 16'd0, 16'd1);
      end

      if (o_CPU_ACK) begin
        if (cpu_q.size() == 0) check("ack_unexpected", 16'd1, 16'd0);
        else begin
          m_e = cpu_q.pop_front();
          check("ack_cycle", cyc[15:0], m_e.cyc[15:0]);
          check("cpu_dout", {12'h0, o_CPU_DOUT}, {12'h0, m_e.data});
        end
      end else if (cpu_q.size() != 0 && cpu_q[0].cyc <= cyc) begin
        m_e = cpu_q.pop_front();
        check("ack_missing", 16'd0, 16'd1);
      end
    end
  end

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {12'h0, o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, 16'hF);
    check("rst_addr", {8'h0, o_ADDR}, 16'h0);
    check("rst_din", {12'h0, o_DIN}, 16'h0);
    check("rst_vdata", {11'h0, o_VDATA_VALID, o_VDATA}, 16'h0);
    check("rst_cpu", {11'h0, o_CPU_ACK, o_CPU_DOUT}, 16'h0);
    @(posedge clk);
    #1;
    i_RST = 1'b0;  // now in cycle 0, video p0

    // Idle CPU for three periods, then address mux on a video slot
    at_cycle(51);
    i_VADDR = 14'h2A5C;
    at_cycle(64); check("row_p0", {8'h0, o_ADDR}, 16'h005C);
    at_cycle(65); check("row_p1", {8'h0, o_ADDR}, 16'h005C);
    at_cycle(66); check("row_p2", {8'h0, o_ADDR}, 16'h005C);
    at_cycle(67); check("col_p3", {8'h0, o_ADDR}, 16'h0054);
    i_VADDR = 14'h0000;

    // Write 9 to 1234, requested at video p3: serviced by CPU slot 88
    at_cycle(83);
    i_CPU_WR = 1'b1; i_CPU_ADDR = 14'h1234; i_CPU_DIN = 4'h9; i_CPU_REQ = 1'b1;
    cpu_kind[88] = K_WR;
    cpu_q.push_back('{94, 4'h0});
    at_cycle(91); check("din_p3", {12'h0, o_DIN}, 16'h9);
    at_cycle(92); check("din_p4", {12'h0, o_DIN}, 16'h9);
    at_cycle(95); i_CPU_REQ = 1'b0;

    // Read 1234, requested at CPU p1: waits for slot 120, ack 21 cycles later
    at_cycle(105);
    i_CPU_WR = 1'b0; i_CPU_REQ = 1'b1;
    cpu_kind[120] = K_RD;
    cpu_q.push_back('{126, 4'h9});
    at_cycle(127); i_CPU_REQ = 1'b0;

    // Read 2A5C requested at video p7 (7-cycle latency), withdrawn at CPU p2
    at_cycle(135);
    i_CPU_ADDR = 14'h2A5C; i_CPU_REQ = 1'b1;
    cpu_kind[136] = K_RD;
    cpu_q.push_back('{142, 4'hB});
    at_cycle(138); i_CPU_REQ = 1'b0;

    // Write aborted by reset at CPU p4
    at_cycle(167);
    i_CPU_WR = 1'b1; i_CPU_ADDR = 14'h0100; i_CPU_DIN = 4'h5; i_CPU_REQ = 1'b1;
    cpu_kind[168] = K_WR;
    at_cycle(172);
    i_RST = 1'b1; i_CPU_REQ = 1'b0;
    cpu_kind.delete();
    cpu_q.delete();
    vid_q.delete();
    @(posedge clk);
    #1;
    check("midrst_strobes", {12'h0, o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, 16'hF);
    check("midrst_ack", {15'h0, o_CPU_ACK}, 16'h0);
    check("midrst_dout", {12'h0, o_CPU_DOUT}, 16'h0);
    check("midrst_addr", {8'h0, o_ADDR}, 16'h0);
    @(posedge clk);
    #1;
    i_RST = 1'b0;
    at_cycle(1);
    check("post_rst_video_ras", {15'h0, o_RAS_n}, 16'h0);
    at_cycle(40);
    check("vid_q_drained", vid_q.size(), 16'd0);
    check("cpu_q_drained", cpu_q.size(), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
